// File: rtl/sample_msg_merger.sv
// Merges a sample stream and a framed message stream into one output stream.
// Build option: SAMPLE_MSG_MERGER_STICKY_ERROR_EN makes error latch until reset.
module sample_msg_merger #(
  parameter int WDTH          = 32,
  parameter int MSG_LEN_WIDTH = 8,
  parameter int SMP_BUF_LOG   = 4,
  parameter int MSG_BUF_LOG   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [WDTH-1:0] in_samples,
  input  logic            in_samples_nd,
  input  logic [WDTH-1:0] in_msg,
  input  logic            in_msg_nd,
  output logic [WDTH-1:0] out_data,
  output logic            out_nd,
  output logic            error
);

  localparam int unsigned SMP_DEPTH = 2 ** SMP_BUF_LOG;
  localparam int unsigned MSG_DEPTH = 2 ** MSG_BUF_LOG;

  typedef logic [SMP_BUF_LOG:0]   smp_ptr_t;
  typedef logic [MSG_BUF_LOG:0]   msg_ptr_t;
  typedef logic [MSG_LEN_WIDTH-1:0] len_t;

  localparam smp_ptr_t SMP_ONE = smp_ptr_t'(1);
  localparam msg_ptr_t MSG_ONE = msg_ptr_t'(1);
  localparam len_t     LEN_ONE = len_t'(1);

  typedef enum logic [1:0] {A_HDR, A_PAY, A_SKIP} asm_state_t;
  typedef enum logic       {O_IDLE, O_MSG}        out_state_t;

  // ---------------------------------------------------------------- samples
  logic [WDTH-1:0] smp_mem [SMP_DEPTH];
  smp_ptr_t        smp_wr_ptr, smp_rd_ptr;
  logic            smp_empty, smp_full, smp_valid, smp_avail;
  logic            smp_we, smp_re, smp_err;
  logic [WDTH-1:0] smp_rd_data;

  assign smp_empty = (smp_wr_ptr == smp_rd_ptr);
  assign smp_full  = (smp_wr_ptr[SMP_BUF_LOG] != smp_rd_ptr[SMP_BUF_LOG]) &&
                     (smp_wr_ptr[SMP_BUF_LOG-1:0] == smp_rd_ptr[SMP_BUF_LOG-1:0]);
  assign smp_valid = in_samples_nd && !in_samples[WDTH-1];
  assign smp_avail = !smp_empty || smp_valid;
  assign smp_we    = smp_valid && (!smp_full || smp_re);
  assign smp_err   = in_samples_nd && (in_samples[WDTH-1] || (smp_full && !smp_re));
  // An empty FIFO forwards the incoming sample so it leaves in the next cycle.
  assign smp_rd_data = smp_empty ? in_samples : smp_mem[smp_rd_ptr[SMP_BUF_LOG-1:0]];

  always_ff @(posedge clk) begin
    if (smp_we) smp_mem[smp_wr_ptr[SMP_BUF_LOG-1:0]] <= in_samples;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_wr_ptr <= '0;
      smp_rd_ptr <= '0;
    end else begin
      if (smp_we) smp_wr_ptr <= smp_wr_ptr + SMP_ONE;
      if (smp_re) smp_rd_ptr <= smp_rd_ptr + SMP_ONE;
    end
  end

  // --------------------------------------------------------------- messages
  logic [WDTH-1:0] msg_mem [MSG_DEPTH];
  msg_ptr_t        msg_wr_ptr, msg_cm_ptr, msg_rd_ptr;
  logic            msg_full, msg_committed, msg_room, msg_avail;
  logic            msg_we, msg_re, commit_now, rewind, msg_err;
  logic [WDTH-1:0] msg_rd_data;
  len_t            in_len, rd_len;
  logic            too_big;
  asm_state_t      asm_state, asm_next;
  len_t            cnt, cnt_next;
  out_state_t      o_state, o_next;

  assign msg_full      = (msg_wr_ptr[MSG_BUF_LOG] != msg_rd_ptr[MSG_BUF_LOG]) &&
                         (msg_wr_ptr[MSG_BUF_LOG-1:0] == msg_rd_ptr[MSG_BUF_LOG-1:0]);
  assign msg_committed = (msg_cm_ptr != msg_rd_ptr);
  // A read is certain this cycle whenever a message is being emitted or committed
  // words wait; that read frees the slot a full FIFO needs for the write.
  assign msg_room      = !msg_full || (o_state == O_MSG) || msg_committed;
  assign msg_avail     = msg_committed || commit_now;
  assign in_len        = in_msg[MSG_LEN_WIDTH-1:0];
  assign too_big       = (32'(in_len) + 32'd1) > MSG_DEPTH;
  // Write-through covers a header-only message committed in the cycle it arrives.
  assign msg_rd_data   = (msg_we && (msg_wr_ptr == msg_rd_ptr)) ? in_msg
                       : msg_mem[msg_rd_ptr[MSG_BUF_LOG-1:0]];
  assign rd_len        = msg_rd_data[MSG_LEN_WIDTH-1:0];

  always_comb begin
    asm_next   = asm_state;
    cnt_next   = cnt;
    msg_we     = 1'b0;
    commit_now = 1'b0;
    rewind     = 1'b0;
    msg_err    = 1'b0;
    if (in_msg_nd) begin
      unique case (asm_state)
        A_HDR: begin
          if (!in_msg[WDTH-1]) begin
            msg_err = 1'b1;
          end else if (too_big || !msg_room) begin
            msg_err = 1'b1;
            cnt_next = in_len;
            if (in_len != '0) asm_next = A_SKIP;
          end else begin
            msg_we   = 1'b1;
            cnt_next = in_len;
            if (in_len == '0) commit_now = 1'b1;
            else              asm_next   = A_PAY;
          end
        end
        A_PAY: begin
          cnt_next = cnt - LEN_ONE;
          if (!msg_room) begin
            rewind   = 1'b1;
            msg_err  = 1'b1;
            asm_next = (cnt == LEN_ONE) ? A_HDR : A_SKIP;
          end else begin
            msg_we = 1'b1;
            if (cnt == LEN_ONE) begin
              commit_now = 1'b1;
              asm_next   = A_HDR;
            end
          end
        end
        A_SKIP: begin
          cnt_next = cnt - LEN_ONE;
          if (cnt == LEN_ONE) asm_next = A_HDR;
        end
        default: asm_next = A_HDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (msg_we) msg_mem[msg_wr_ptr[MSG_BUF_LOG-1:0]] <= in_msg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_state  <= A_HDR;
      cnt        <= '0;
      msg_wr_ptr <= '0;
      msg_cm_ptr <= '0;
      msg_rd_ptr <= '0;
    end else begin
      asm_state <= asm_next;
      cnt       <= cnt_next;
      if (rewind)      msg_wr_ptr <= msg_cm_ptr;
      else if (msg_we) msg_wr_ptr <= msg_wr_ptr + MSG_ONE;
      if (commit_now)  msg_cm_ptr <= msg_wr_ptr + MSG_ONE;
      if (msg_re)      msg_rd_ptr <= msg_rd_ptr + MSG_ONE;
    end
  end

  // ----------------------------------------------------------------- output
  len_t            rem, rem_next;
  logic [WDTH-1:0] out_data_next;
  logic            out_nd_next;

  always_comb begin
    o_next        = o_state;
    rem_next      = rem;
    msg_re        = 1'b0;
    smp_re        = 1'b0;
    out_nd_next   = 1'b0;
    out_data_next = out_data;
    unique case (o_state)
      O_IDLE: begin
        if (msg_avail) begin
          msg_re        = 1'b1;
          out_nd_next   = 1'b1;
          out_data_next = msg_rd_data;
          if (rd_len != '0) begin
            o_next   = O_MSG;
            rem_next = rd_len;
          end
        end else if (smp_avail) begin
          smp_re        = 1'b1;
          out_nd_next   = 1'b1;
          out_data_next = smp_rd_data;
        end
      end
      O_MSG: begin
        msg_re        = 1'b1;
        out_nd_next   = 1'b1;
        out_data_next = msg_rd_data;
        rem_next      = rem - LEN_ONE;
        if (rem == LEN_ONE) o_next = O_IDLE;
      end
      default: o_next = O_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_state  <= O_IDLE;
      rem      <= '0;
      out_data <= '0;
      out_nd   <= 1'b0;
    end else begin
      o_state  <= o_next;
      rem      <= rem_next;
      out_data <= out_data_next;
      out_nd   <= out_nd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else begin
`ifdef SAMPLE_MSG_MERGER_STICKY_ERROR_EN
      error <= error | smp_err | msg_err;
`else
      error <= smp_err | msg_err;
`endif
    end
  end

endmodule

// File: tb/tb_sample_msg_merger.sv
// Bench for sample_msg_merger: directed vector table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sample_msg_merger;

  localparam int MSG_DEPTH = 64;
  localparam int SMP_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_samples, in_msg, out_data;
  logic        in_samples_nd, in_msg_nd, out_nd, error;

  always #5 clk = ~clk;

  sample_msg_merger #(
    .WDTH(32), .MSG_LEN_WIDTH(8), .SMP_BUF_LOG(4), .MSG_BUF_LOG(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_samples(in_samples), .in_samples_nd(in_samples_nd),
    .in_msg(in_msg), .in_msg_nd(in_msg_nd),
    .out_data(out_data), .out_nd(out_nd), .error(error)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------- reference model
  logic [31:0] cq[$];   // committed, not yet emitted message words
  logic [31:0] pq[$];   // message under assembly
  logic [31:0] sq[$];   // buffered samples
  int          asm_mode, asm_left, emit_left;
  logic        m_nd, m_err;
  logic [31:0] m_data;

  task automatic model_reset();
    cq.delete(); pq.delete(); sq.delete();
    asm_mode = 0; asm_left = 0; emit_left = 0;
    m_nd = 1'b0; m_err = 1'b0; m_data = '0;
  endtask

  task automatic commit_pq();
    foreach (pq[i]) cq.push_back(pq[i]);
    pq.delete();
  endtask

  task automatic model_step();
    logic e;
    int   len;
    bit   rd_msg, rd_smp, room;
    e      = 1'b0;
    rd_msg = (emit_left > 0) || (cq.size() > 0);
    room   = (cq.size() + pq.size() - (rd_msg ? 1 : 0)) < MSG_DEPTH;
    if (in_msg_nd) begin
      case (asm_mode)
        0: begin
          if (!in_msg[31]) e = 1'b1;
          else begin
            len = int'(in_msg[7:0]);
            if (len + 1 > MSG_DEPTH || !room) begin
              e = 1'b1;
              if (len > 0) begin asm_mode = 2; asm_left = len; end
            end else begin
              pq.push_back(in_msg);
              if (len == 0) commit_pq();
              else begin asm_mode = 1; asm_left = len; end
            end
          end
        end
        1: begin
          asm_left--;
          if (room) begin
            pq.push_back(in_msg);
            if (asm_left == 0) begin commit_pq(); asm_mode = 0; end
          end else begin
            pq.delete(); e = 1'b1;
            asm_mode = (asm_left == 0) ? 0 : 2;
          end
        end
        default: begin
          asm_left--;
          if (asm_left == 0) asm_mode = 0;
        end
      endcase
    end
    if (in_samples_nd) begin
      if (in_samples[31]) e = 1'b1;
      else begin
        rd_smp = (emit_left == 0) && (cq.size() == 0);
        if (sq.size() < SMP_DEPTH || rd_smp) sq.push_back(in_samples);
        else e = 1'b1;
      end
    end
    if (emit_left > 0) begin
      m_nd = 1'b1; m_data = cq.pop_front(); emit_left--;
    end else if (cq.size() > 0) begin
      m_nd = 1'b1; m_data = cq.pop_front(); emit_left = int'(m_data[7:0]);
    end else if (sq.size() > 0) begin
      m_nd = 1'b1; m_data = sq.pop_front();
    end else begin
      m_nd = 1'b0;
    end
`ifdef SAMPLE_MSG_MERGER_STICKY_ERROR_EN
    m_err = m_err | e;
`else
    m_err = e;
`endif
  endtask

  task automatic tick();
    if (rst_n) model_step();
    else       model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic snd, input logic [31:0] s, input logic mnd, input logic [31:0] m);
    in_samples_nd = snd; in_samples = s; in_msg_nd = mnd; in_msg = m;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic        snd;
    logic [31:0] s;
    logic        mnd;
    logic [31:0] m;
    logic        exp_nd;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic snd, input logic [31:0] s, input logic mnd,
                              input logic [31:0] m, input logic xnd, input logic [31:0] xd,
                              input logic xe);
    vec_t v;
    v.snd = snd; v.s = s; v.mnd = mnd; v.m = m;
    v.exp_nd = xnd; v.exp_d = xd; v.exp_e = xe;
    tbl.push_back(v);
  endfunction

  logic [31:0] got[$];
  int          err_edges;
  logic        prev_err;

  task automatic tick_collect();
    tick();
    if (out_nd) got.push_back(out_data);
    if (error && !prev_err) err_edges++;
    prev_err = error;
  endtask

  int gen_left;

  task automatic gen_msg_word(output logic [31:0] w);
    int r, len;
    if (gen_left > 0) begin
      w = $urandom; gen_left--;
    end else begin
      r = $urandom_range(99);
      if (r < 5) w = $urandom & 32'h7fff_ffff;
      else begin
        if (r < 70)      len = $urandom_range(6);
        else if (r < 92) len = $urandom_range(63, 20);
        else             len = $urandom_range(90, 64);
        w = 32'h8000_0000 | 32'(len);
        gen_left = len;
      end
    end
  endtask

  initial begin
    logic        sticky;
    logic        want_e;
    logic [31:0] w;
    int          ph;
    int          smp_pct[4];
    int          msg_pct[4];
    smp_pct = '{20, 60, 95, 100};
    msg_pct = '{40, 70, 100, 50};

    model_reset();
    do_reset();
    check("reset_nd", 32'(out_nd), 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_err", 32'(error), 32'd0);

    for (int i = 1; i <= 5; i++) add(1, 32'(i), 0, 0, 1, 32'(i), 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h10, 0, 0,            1, 32'h10, 0);
    add(1, 32'h11, 1, 32'h80000002, 1, 32'h11, 0);
    add(1, 32'h12, 1, 32'hAAAA0000, 1, 32'h12, 0);
    add(1, 32'h13, 1, 32'hBBBB0000, 1, 32'h80000002, 0);
    add(1, 32'h14, 0, 0,            1, 32'hAAAA0000, 0);
    add(1, 32'h15, 0, 0,            1, 32'hBBBB0000, 0);
    add(1, 32'h16, 0, 0,            1, 32'h13, 0);
    add(1, 32'h17, 0, 0,            1, 32'h14, 0);
    add(0, 0, 0, 0, 1, 32'h15, 0);
    add(0, 0, 0, 0, 1, 32'h16, 0);
    add(0, 0, 0, 0, 1, 32'h17, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'h80000000, 1, 32'h80000000, 0);
    add(0, 0, 1, 32'h80000001, 0, 0, 0);
    add(0, 0, 1, 32'h12345678, 1, 32'h80000001, 0);
    add(0, 0, 0, 0,            1, 32'h12345678, 0);
    add(0, 0, 0, 0,            0, 0, 0);
    add(0, 0, 1, 32'h00000007, 0, 0, 1);
    add(1, 32'h80000001, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,            0, 0, 0);

    sticky = 1'b0;
    foreach (tbl[i]) begin
      drive(tbl[i].snd, tbl[i].s, tbl[i].mnd, tbl[i].m);
      tick();
      sticky = sticky | tbl[i].exp_e;
`ifdef SAMPLE_MSG_MERGER_STICKY_ERROR_EN
      want_e = sticky;
`else
      want_e = tbl[i].exp_e;
`endif
      check($sformatf("vec%0d_nd", i), 32'(out_nd), 32'(tbl[i].exp_nd));
      if (tbl[i].exp_nd) check($sformatf("vec%0d_data", i), out_data, tbl[i].exp_d);
      check($sformatf("vec%0d_err", i), 32'(error), 32'(want_e));
    end

    // Oversized message is skipped whole; the following message survives.
    do_reset();
    got.delete(); err_edges = 0; prev_err = error;
    drive(0, 0, 1, 32'h800000FF);
    tick_collect();
    for (int i = 0; i < 255; i++) begin
      drive(0, 0, 1, (i % 2 == 1) ? (32'h8000_0000 | 32'(i)) : 32'(i * 32'h0101_0101));
      tick_collect();
    end
    drive(0, 0, 1, 32'h80000001); tick_collect();
    drive(0, 0, 1, 32'h12345678); tick_collect();
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick_collect();
    check("big_err_events", 32'(err_edges), 32'd1);
    check("big_out_count", 32'(got.size()), 32'd2);
    if (got.size() >= 2) begin
      check("big_out0", got[0], 32'h80000001);
      check("big_out1", got[1], 32'h12345678);
    end

    // Reset while a message is being emitted.
    do_reset();
    drive(0, 0, 1, 32'h80000004); tick();
    for (int i = 1; i <= 4; i++) begin drive(0, 0, 1, 32'hC0DE_0000 + 32'(i)); tick(); end
    drive(0, 0, 0, 0);
    check("rst_mid_hdr", out_data, 32'h80000004);
    tick(); check("rst_mid_w1", out_data, 32'hC0DE_0001);
    tick(); check("rst_mid_w2", out_data, 32'hC0DE_0002);
    rst_n = 1'b0; tick();
    check("rst_mid_nd", 32'(out_nd), 32'd0);
    check("rst_mid_data", out_data, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rst_quiet%0d", i), 32'(out_nd), 32'd0);
    end
    drive(1, 32'h55, 0, 0); tick();
    check("rst_smp_next", out_data, 32'h55);
    drive(0, 0, 1, 32'h80000000); tick();
    check("rst_msg_next", out_data, 32'h80000000);
    drive(0, 0, 0, 0); tick();

    // Randomized traffic against the model.
    do_reset();
    gen_left = 0;
    for (int c = 0; c < 4000; c++) begin
      ph = (c / 500) % 4;
      if ($urandom_range(99) < smp_pct[ph]) begin
        w = $urandom & 32'h7fff_ffff;
        if ($urandom_range(99) < 3) w[31] = 1'b1;
        in_samples_nd = 1'b1; in_samples = w;
      end else begin
        in_samples_nd = 1'b0; in_samples = $urandom;
      end
      if ($urandom_range(99) < msg_pct[ph]) begin
        gen_msg_word(w);
        in_msg_nd = 1'b1; in_msg = w;
      end else begin
        in_msg_nd = 1'b0; in_msg = $urandom;
      end
      tick();
      check("rnd_nd", 32'(out_nd), 32'(m_nd));
      if (m_nd) check("rnd_data", out_data, m_data);
      check("rnd_err", 32'(error), 32'(m_err));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
